// File: rtl/fifo_stream_drain.sv
// Read-side drain for a synchronous FIFO: issues reads against buffer credit,
// absorbs the one-cycle read latency and streams words out on valid/ready.
module fifo_stream_drain #(
  parameter int DATA_WIDTH = 16,
  parameter int BUF_DEPTH  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  words_sent,
  output logic                  busy
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OW = $clog2(BUF_DEPTH + 1);
  localparam logic [PW-1:0] LAST    = PW'(BUF_DEPTH - 1);
  localparam logic [OW:0]   DEPTH_W = (OW + 1)'(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [OW-1:0]         occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0]  sent_q, sent_d;
  logic [OW:0]           pending;
  logic                  credit_ok;
  logic                  push;
  logic                  pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Credit counts the in-flight word so a capture can never overflow.
  always_comb begin
    pending   = {1'b0, occ_q} + {{OW{1'b0}}, inflight_q};
    credit_ok = (pending < DEPTH_W);
  end

  always_comb begin
    m_valid    = (occ_q != '0);
    busy       = m_valid | inflight_q;
    m_data     = buf_q[head_q];
    words_sent = sent_q;
    fifo_rd_en = !rst && en && !fifo_empty && credit_ok;
  end

  assign push = inflight_q;
  assign pop  = m_valid & m_ready;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    sent_d     = sent_q;
    inflight_d = fifo_rd_en;
    if (push) begin
      tail_d = wrap_inc(tail_q);
    end
    if (pop) begin
      head_d = wrap_inc(head_q);
      sent_d = sent_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      sent_q     <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      sent_q     <= sent_d;
      if (push) begin
        buf_q[tail_q] <= fifo_dout;
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: behavioural FIFO source, credit/occupancy
// model from the word counts, and an in-order scoreboard on the stream.
module tb_fifo_stream_drain;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        m_ready = 1'b0;
  logic        fifo_empty;
  logic [15:0] fifo_dout = '0;
  logic        fifo_rd_en;
  logic        m_valid;
  logic [15:0] m_data;
  logic [15:0] words_sent;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem [0:131071];
  int wp = 0;
  int rp = 0;

  int iss = 0, dlv = 0, sb = 0, ndeliv = 0;
  int prev_rd = 0, pend = 0;
  logic [15:0] exp_sent = '0;

  fifo_stream_drain dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_rd_en(fifo_rd_en),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .words_sent(words_sent),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] d);
    mem[wp] = d;
    wp++;
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  // Source FIFO: one-cycle read latency, flushed by the shared reset.
  assign fifo_empty = (rp == wp);
  always @(posedge clk) begin
    if (rst) begin
      rp <= wp;
    end else if (fifo_rd_en) begin
      fifo_dout <= mem[rp];
      rp <= rp + 1;
    end
  end

  // Reference: outstanding = reads issued - words delivered.
  always @(negedge clk) begin
    int outst, occ, hs, rd_exp;
    if (rst) begin
      chk("rst_rd_en", int'(fifo_rd_en), 0);
      ndeliv += pend;
      iss = 0; dlv = 0; prev_rd = 0; pend = 0;
      exp_sent = '0;
      sb = wp;
    end else begin
      iss += prev_rd;
      dlv += pend;
      if (pend != 0) begin
        exp_sent = exp_sent + 16'd1;
        ndeliv++;
      end
      outst = iss - dlv;
      occ = outst - prev_rd;
      chk("bound", int'(outst <= 3), 1);
      chk("m_valid", int'(m_valid), int'(occ != 0));
      chk("busy", int'(busy), int'(outst != 0));
      chk("words_sent", int'(words_sent), int'(exp_sent));
      rd_exp = int'(en && !fifo_empty && outst < 3);
      chk("rd_en", int'(fifo_rd_en), rd_exp);
      chk("rd_empty", int'(fifo_rd_en && fifo_empty), 0);
      hs = int'(m_valid && m_ready);
      if (hs != 0) begin
        chk("data", int'(m_data), int'(mem[sb]));
        sb++;
      end
      prev_rd = int'(fifo_rd_en);
      pend = hs;
    end
  end

  initial begin
    int rf, rl, rc, vf, vl, vc, d0, c;
    repeat (2) drv();
    rst = 1'b0;
    nxt();
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sent", int'(words_sent), 0);
    chk("rst_data", int'(m_data), 0);

    // Preloaded burst, free-running sink.
    for (int i = 1; i <= 8; i++) push(16'(i));
    drv();
    en = 1'b1;
    m_ready = 1'b1;
    rf = -1; rl = -1; rc = 0; vf = -1; vl = -1; vc = 0;
    for (int i = 0; i < 14; i++) begin
      nxt();
      if (fifo_rd_en) begin
        if (rf < 0) rf = i;
        rl = i;
        rc++;
      end
      if (m_valid) begin
        if (vf < 0) vf = i;
        vl = i;
        vc++;
      end
    end
    chk("t1_rd_cnt", rc, 8);
    chk("t1_rd_run", rl - rf + 1, 8);
    chk("t1_latency", vf - rf, 2);
    chk("t1_v_cnt", vc, 8);
    chk("t1_v_run", vl - vf + 1, 8);
    chk("t1_sent", int'(words_sent), 8);
    chk("t1_busy", int'(busy), 0);

    // Stalled sink: credit limit, head held, gapless restart.
    drv();
    en = 1'b0;
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(16'(i));
    en = 1'b1;
    c = 0;
    repeat (10) begin
      nxt();
      c += int'(fifo_rd_en);
    end
    chk("t2_rd_pulses", c, 3);
    chk("t2_hold", int'(m_data), 1);
    chk("t2_valid", int'(m_valid), 1);
    d0 = ndeliv;
    drv();
    m_ready = 1'b1;
    c = 0;
    repeat (8) begin
      nxt();
      c += int'(m_valid);
    end
    chk("t2_no_gap", c, 8);
    nxt();
    chk("t2_drained", ndeliv - d0, 8);

    // Toggling ready over 20 words.
    drv();
    en = 1'b0;
    for (int i = 0; i < 20; i++) push(16'hA000 + 16'(i));
    en = 1'b1;
    d0 = ndeliv;
    for (int i = 0; i < 200 && (ndeliv - d0) < 20; i++) begin
      drv();
      m_ready = ~m_ready;
    end
    m_ready = 1'b1;
    repeat (4) nxt();
    chk("t3_count", ndeliv - d0, 20);
    chk("t3_sent", int'(words_sent), 36);

    // Enable dropped right after one read.
    drv();
    en = 1'b0;
    for (int i = 0; i < 4; i++) push(16'hB000 + 16'(i));
    en = 1'b1;
    d0 = ndeliv;
    for (int i = 0; i < 10 && !fifo_rd_en; i++) nxt();
    chk("t4_rd_seen", int'(fifo_rd_en), 1);
    drv();
    en = 1'b0;
    c = 0;
    repeat (8) begin
      nxt();
      c += int'(fifo_rd_en);
    end
    chk("t4_no_rd", c, 0);
    chk("t4_one_word", ndeliv - d0, 1);
    chk("t4_sent", int'(words_sent), 37);
    drv();
    en = 1'b1;
    repeat (12) nxt();
    chk("t4_rest", ndeliv - d0, 4);

    // Reset with occupancy 2 and a read in flight.
    drv();
    en = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(16'hC000 + 16'(i));
    en = 1'b1;
    c = 0;
    for (int i = 0; i < 10 && c < 3; i++) begin
      nxt();
      c += int'(fifo_rd_en);
    end
    chk("t5_reads", c, 3);
    drv();
    rst = 1'b1;
    nxt();
    chk("t5_rd_in_rst", int'(fifo_rd_en), 0);
    drv();
    rst = 1'b0;
    nxt();
    chk("t5_valid", int'(m_valid), 0);
    chk("t5_sent", int'(words_sent), 0);
    chk("t5_busy", int'(busy), 0);

    // Random enable/ready/arrival mix.
    drv();
    for (int i = 0; i < 300; i++) begin
      drv();
      en = ($urandom_range(0, 3) != 0);
      m_ready = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 2) != 0) push(16'($urandom));
    end
    en = 1'b1;
    m_ready = 1'b1;
    d0 = 0;
    for (int i = 0; i < 400 && !(fifo_empty && !busy); i++) nxt();
    chk("t6_drained", int'(fifo_empty && !busy), 1);
    chk("t6_sent", int'(words_sent), int'(exp_sent));

    // Counter wrap.
    drv();
    rst = 1'b1;
    en = 1'b0;
    drv();
    rst = 1'b0;
    for (int i = 0; i < 65537; i++) push(16'($urandom));
    en = 1'b1;
    d0 = ndeliv;
    for (int i = 0; i < 70000 && (ndeliv - d0) < 65535; i++) nxt();
    chk("t7_count", ndeliv - d0, 65535);
    chk("t7_ffff", int'(words_sent), 32'hFFFF);
    nxt();
    chk("t7_wrap0", int'(words_sent), 0);
    nxt();
    chk("t7_wrap1", int'(words_sent), 1);
    chk("t7_total", ndeliv - d0, 65537);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
